// File: rtl/phase_pulse_checker.sv
// -----------------------------------------------------------------------------
// phase_pulse_checker
//
// Receive-side monitor for the three-phase strobe generator. It watches the
// data-out, set-data and state-out pulses, rebuilds the frame phase from the
// data pulse, and checks that every pulse lands where the schedule says it
// should. It reports lock, the rebuilt phase, a frame-start strobe, and error
// events with a code and a saturating count.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   data_pulse   data-out strobe (single-cycle)
//   set_pulse    set-data strobe (single-cycle)
//   state_pulse  state-out strobe (single-cycle)
//   clr_err      synchronous clear of err_count / err_code
//   locked       schedule verified for LOCK_FRAMES consecutive frames
//   frame_start  one-cycle pulse after a correctly placed data_pulse while locked
//   phase_idx    rebuilt phase of the previous cycle (0 while hunting)
//   err_pulse    one-cycle error event
//   err_code     code of the most recent error
//   err_count    saturating error count
//
// Optional feature (macro PHASE_CHK_FIRST_ERR_EN):
//   first_err_code   code of the first error since reset / clr_err
//   first_err_phase  phase at which that first error happened
//
// Error codes: 7 multiple pulses in one cycle, 1/2 data missing/misplaced,
// 3/4 set missing/misplaced, 5/6 state missing/misplaced.
// -----------------------------------------------------------------------------
module phase_pulse_checker #(
  parameter int FRAME_LEN   = 11,
  parameter int DATA_POS    = 2,
  parameter int SET_POS     = 4,
  parameter int STATE_POS   = 6,
  parameter int LOCK_FRAMES = 3,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_pulse,
  input  logic                 set_pulse,
  input  logic                 state_pulse,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 frame_start,
  output logic [3:0]           phase_idx,
  output logic                 err_pulse,
  output logic [2:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef PHASE_CHK_FIRST_ERR_EN
  ,
  output logic [2:0]           first_err_code,
  output logic [3:0]           first_err_phase
`endif
);

  // Parameter sanity: the phase counter is 4 bits and the three pulse slots
  // must be distinct, in-frame positions.
  generate
    if (FRAME_LEN > 16 || FRAME_LEN < 2) begin : gBadFrameLen
      $error("phase_pulse_checker: FRAME_LEN must be in 2..16");
    end
    if (DATA_POS < 0 || SET_POS < 0 || STATE_POS < 0 ||
        DATA_POS >= FRAME_LEN || SET_POS >= FRAME_LEN || STATE_POS >= FRAME_LEN) begin : gBadPos
      $error("phase_pulse_checker: pulse positions must lie inside the frame");
    end
    if (DATA_POS == SET_POS || DATA_POS == STATE_POS || SET_POS == STATE_POS) begin : gDupPos
      $error("phase_pulse_checker: pulse positions must be distinct");
    end
    if (LOCK_FRAMES < 1 || ERR_CNT_W < 1) begin : gBadWidths
      $error("phase_pulse_checker: LOCK_FRAMES and ERR_CNT_W must be at least 1");
    end
  endgenerate

  localparam int GW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [3:0]    DATA_PH   = 4'(DATA_POS);
  localparam logic [3:0]    SET_PH    = 4'(SET_POS);
  localparam logic [3:0]    STATE_PH  = 4'(STATE_POS);
  localparam logic [3:0]    LAST_PH   = 4'(FRAME_LEN - 1);
  localparam logic [3:0]    RESYNC_PH = 4'((DATA_POS + 1) % FRAME_LEN);
  localparam logic [GW-1:0] LOCK_G    = GW'(LOCK_FRAMES);

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             ph_q, ph_d;
  logic [GW-1:0]          goodFrames_q, goodFrames_d;
  logic                   locked_q, locked_d;
  logic                   frameStart_q, frameStart_d;
  logic [3:0]             phaseIdx_q, phaseIdx_d;
  logic                   errPulse_q, errPulse_d;
  logic [2:0]             errCode_q, errCode_d;
  logic [ERR_CNT_W-1:0]   errCount_q, errCount_d;

  logic                   multiPulse;
  logic                   errHit;
  logic [2:0]             errNow;

`ifdef PHASE_CHK_FIRST_ERR_EN
  logic                   firstValid_q, firstValid_d;
  logic [2:0]             firstCode_q, firstCode_d;
  logic [3:0]             firstPhase_q, firstPhase_d;
`endif

  assign multiPulse = (data_pulse & set_pulse) | (data_pulse & state_pulse) |
                      (set_pulse & state_pulse);

  // Phase tracking FSM. HUNT waits for a lone data pulse to anchor the phase;
  // TRACK advances the phase every cycle and classifies each pulse against it.
  // Any error drops back to HUNT, and the erroring cycle never resyncs.
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    goodFrames_d = goodFrames_q;
    locked_d     = locked_q;
    frameStart_d = 1'b0;
    phaseIdx_d   = (state_q == TRACK) ? ph_q : 4'd0;
    errHit       = 1'b0;
    errNow       = 3'd0;

    if (state_q == HUNT) begin
      ph_d         = 4'd0;
      goodFrames_d = '0;
      locked_d     = 1'b0;
      if (data_pulse) begin
        if (multiPulse) begin
          errHit = 1'b1;
          errNow = 3'd7;
        end else begin
          state_d = TRACK;
          ph_d    = RESYNC_PH;
        end
      end
    end else begin
      // Collision beats every slot check; the slot checks are ordered by code.
      if (multiPulse) begin
        errHit = 1'b1; errNow = 3'd7;
      end else if (ph_q == DATA_PH && !data_pulse) begin
        errHit = 1'b1; errNow = 3'd1;
      end else if (ph_q != DATA_PH && data_pulse) begin
        errHit = 1'b1; errNow = 3'd2;
      end else if (ph_q == SET_PH && !set_pulse) begin
        errHit = 1'b1; errNow = 3'd3;
      end else if (ph_q != SET_PH && set_pulse) begin
        errHit = 1'b1; errNow = 3'd4;
      end else if (ph_q == STATE_PH && !state_pulse) begin
        errHit = 1'b1; errNow = 3'd5;
      end else if (ph_q != STATE_PH && state_pulse) begin
        errHit = 1'b1; errNow = 3'd6;
      end

      ph_d = (ph_q == LAST_PH) ? 4'd0 : ph_q + 4'd1;

      if (errHit) begin
        state_d      = HUNT;
        ph_d         = 4'd0;
        goodFrames_d = '0;
        locked_d     = 1'b0;
      end else begin
        // Reaching the last phase cleanly means the whole frame was clean,
        // because any earlier error would have sent us back to HUNT.
        if (ph_q == LAST_PH && goodFrames_q != LOCK_G) begin
          goodFrames_d = goodFrames_q + GW'(1);
        end
        if (goodFrames_d == LOCK_G) begin
          locked_d = 1'b1;
        end
        // Without an error a data pulse can only be at DATA_POS.
        if (data_pulse && locked_q) begin
          frameStart_d = 1'b1;
        end
      end
    end
  end

  // Error reporting. The clear is applied before a same-cycle error so the
  // new error becomes the first one counted.
  always_comb begin
    errPulse_d = errHit;
    errCode_d  = clr_err ? 3'd0 : errCode_q;
    errCount_d = clr_err ? '0 : errCount_q;
`ifdef PHASE_CHK_FIRST_ERR_EN
    firstValid_d = clr_err ? 1'b0 : firstValid_q;
    firstCode_d  = clr_err ? 3'd0 : firstCode_q;
    firstPhase_d = clr_err ? 4'd0 : firstPhase_q;
`endif
    if (errHit) begin
      errCode_d = errNow;
      if (errCount_d != '1) begin
        errCount_d = errCount_d + ERR_CNT_W'(1);
      end
`ifdef PHASE_CHK_FIRST_ERR_EN
      if (!firstValid_d) begin
        firstValid_d = 1'b1;
        firstCode_d  = errNow;
        firstPhase_d = ph_q;
      end
`endif
    end
  end

  // All state and output registers share the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      ph_q         <= 4'd0;
      goodFrames_q <= '0;
      locked_q     <= 1'b0;
      frameStart_q <= 1'b0;
      phaseIdx_q   <= 4'd0;
      errPulse_q   <= 1'b0;
      errCode_q    <= 3'd0;
      errCount_q   <= '0;
`ifdef PHASE_CHK_FIRST_ERR_EN
      firstValid_q <= 1'b0;
      firstCode_q  <= 3'd0;
      firstPhase_q <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      goodFrames_q <= goodFrames_d;
      locked_q     <= locked_d;
      frameStart_q <= frameStart_d;
      phaseIdx_q   <= phaseIdx_d;
      errPulse_q   <= errPulse_d;
      errCode_q    <= errCode_d;
      errCount_q   <= errCount_d;
`ifdef PHASE_CHK_FIRST_ERR_EN
      firstValid_q <= firstValid_d;
      firstCode_q  <= firstCode_d;
      firstPhase_q <= firstPhase_d;
`endif
    end
  end

  assign locked      = locked_q;
  assign frame_start = frameStart_q;
  assign phase_idx   = phaseIdx_q;
  assign err_pulse   = errPulse_q;
  assign err_code    = errCode_q;
  assign err_count   = errCount_q;
`ifdef PHASE_CHK_FIRST_ERR_EN
  assign first_err_code  = firstCode_q;
  assign first_err_phase = firstPhase_q;
`endif

endmodule

// File: tb/tb_phase_pulse_checker.sv
// -----------------------------------------------------------------------------
// tb_phase_pulse_checker
//
// Drives generator-like frames with directed faults and a randomized section
// into two checker instances (8-bit and 2-bit error counters). A cycle-count
// reference model derives the frame phase from the resync cycle number and
// predicts every output; a few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_phase_pulse_checker;

  localparam int FRAME_LEN   = 11;
  localparam int DATA_POS    = 2;
  localparam int SET_POS     = 4;
  localparam int STATE_POS   = 6;
  localparam int LOCK_FRAMES = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dataPulse = 1'b0;
  logic       setPulse = 1'b0;
  logic       statePulse = 1'b0;
  logic       clrErr = 1'b0;

  logic       locked8, frameStart8, errPulse8;
  logic [3:0] phaseIdx8;
  logic [2:0] errCode8;
  logic [7:0] errCount8;
  logic       locked2, frameStart2, errPulse2;
  logic [3:0] phaseIdx2;
  logic [2:0] errCode2;
  logic [1:0] errCount2;
`ifdef PHASE_CHK_FIRST_ERR_EN
  logic [2:0] firstCode8, firstCode2;
  logic [3:0] firstPhase8, firstPhase2;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int genPhase    = 0;

  // Reference model state: phase comes from cycle arithmetic since resync.
  bit   mSynced;
  int   mSyncCyc, mCyc, mFrameEnds;
  bit   mLocked;
  int   mCode, mCnt8, mCnt2;
  bit   mFirstValid;
  int   mFirstCode, mFirstPhase;
  bit   eErrPulse, eFrameStart;
  int   ePhaseIdx;

  always #5 clk = ~clk;

  phase_pulse_checker #(.ERR_CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .data_pulse(dataPulse), .set_pulse(setPulse),
    .state_pulse(statePulse), .clr_err(clrErr), .locked(locked8),
    .frame_start(frameStart8), .phase_idx(phaseIdx8), .err_pulse(errPulse8),
    .err_code(errCode8), .err_count(errCount8)
`ifdef PHASE_CHK_FIRST_ERR_EN
    , .first_err_code(firstCode8), .first_err_phase(firstPhase8)
`endif
  );

  phase_pulse_checker #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .data_pulse(dataPulse), .set_pulse(setPulse),
    .state_pulse(statePulse), .clr_err(clrErr), .locked(locked2),
    .frame_start(frameStart2), .phase_idx(phaseIdx2), .err_pulse(errPulse2),
    .err_code(errCode2), .err_count(errCount2)
`ifdef PHASE_CHK_FIRST_ERR_EN
    , .first_err_code(firstCode2), .first_err_phase(firstPhase2)
`endif
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mSynced = 0; mSyncCyc = 0; mCyc = 0; mFrameEnds = 0; mLocked = 0;
    mCode = 0; mCnt8 = 0; mCnt2 = 0;
    mFirstValid = 0; mFirstCode = 0; mFirstPhase = 0;
    eErrPulse = 0; eFrameStart = 0; ePhaseIdx = 0;
  endtask

  task automatic modelStep(input bit d, input bit s, input bit t, input bit c);
    int np, phase, ec;
    np = int'(d) + int'(s) + int'(t);
    ec = 0;
    phase = 0;
    eErrPulse = 0;
    eFrameStart = 0;
    if (mSynced) phase = (mCyc - mSyncCyc + DATA_POS) % FRAME_LEN;
    ePhaseIdx = mSynced ? phase : 0;
    if (!mSynced) begin
      if (d && np > 1) ec = 7;
      else if (d) begin
        mSynced = 1; mSyncCyc = mCyc; mFrameEnds = 0;
      end
    end else begin
      if (np > 1) ec = 7;
      else if ((phase == DATA_POS) != d) ec = d ? 2 : 1;
      else if ((phase == SET_POS) != s) ec = s ? 4 : 3;
      else if ((phase == STATE_POS) != t) ec = t ? 6 : 5;
      if (ec == 0) begin
        if (d && mLocked) eFrameStart = 1;
        if (phase == FRAME_LEN - 1) mFrameEnds++;
        mLocked = (mFrameEnds >= LOCK_FRAMES);
      end
    end
    if (c) begin
      mCode = 0; mCnt8 = 0; mCnt2 = 0;
      mFirstValid = 0; mFirstCode = 0; mFirstPhase = 0;
    end
    if (ec != 0) begin
      eErrPulse = 1;
      mSynced = 0;
      mLocked = 0;
      mCode = ec;
      if (mCnt8 < 255) mCnt8++;
      if (mCnt2 < 3) mCnt2++;
      if (!mFirstValid) begin
        mFirstValid = 1; mFirstCode = ec; mFirstPhase = phase;
      end
    end
    mCyc++;
  endtask

  // Single compare process: step the model on each active edge, then compare
  // shortly after the edge once the registered outputs have settled.
  initial begin
    modelReset();
    forever begin
      @(posedge clk);
      if (rst) modelReset();
      else modelStep(dataPulse, setPulse, statePulse, clrErr);
      #1;
      checkOutput("locked", int'(locked8), int'(mLocked));
      checkOutput("frame_start", int'(frameStart8), int'(eFrameStart));
      checkOutput("phase_idx", int'(phaseIdx8), ePhaseIdx);
      checkOutput("err_pulse", int'(errPulse8), int'(eErrPulse));
      checkOutput("err_code", int'(errCode8), mCode);
      checkOutput("err_count8", int'(errCount8), mCnt8);
      checkOutput("err_count2", int'(errCount2), mCnt2);
      checkOutput("err_code2", int'(errCode2), mCode);
      checkOutput("locked2", int'(locked2), int'(mLocked));
`ifdef PHASE_CHK_FIRST_ERR_EN
      checkOutput("first_err_code", int'(firstCode8), mFirstCode);
      checkOutput("first_err_phase", int'(firstPhase8), mFirstPhase);
      checkOutput("first_err_code2", int'(firstCode2), mFirstCode);
`endif
    end
  end

  // Drive one cycle's inputs at a falling edge and return at the next one,
  // by which time the cycle has been sampled and its outputs are visible.
  task automatic applyStimulus(input logic d, input logic s, input logic t, input logic c);
    dataPulse = d; setPulse = s; statePulse = t; clrErr = c;
    genPhase = (genPhase + 1) % FRAME_LEN;
    @(negedge clk);
  endtask

  task automatic cleanCycle();
    applyStimulus(genPhase == DATA_POS, genPhase == SET_POS, genPhase == STATE_POS, 1'b0);
  endtask

  task automatic cleanCycles(input int n);
    for (int i = 0; i < n; i++) cleanCycle();
  endtask

  task automatic advanceTo(input int p);
    while (genPhase != p) cleanCycle();
  endtask

  task automatic doReset();
    rst = 1'b1;
    dataPulse = 0; setPulse = 0; statePulse = 0; clrErr = 0;
    #1;
    checkOutput("rst_locked", int'(locked8), 0);
    checkOutput("rst_frame_start", int'(frameStart8), 0);
    checkOutput("rst_phase_idx", int'(phaseIdx8), 0);
    checkOutput("rst_err_pulse", int'(errPulse8), 0);
    checkOutput("rst_err_code", int'(errCode8), 0);
    checkOutput("rst_err_count", int'(errCount8), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    checkOutput("init_err_count", int'(errCount8), 0);
    checkOutput("init_locked", int'(locked8), 0);
    @(negedge clk);
    rst = 1'b0;
    genPhase = 0;

    // Clean lock: partial frame 0 plus frames 1 and 2 give three clean frames.
    cleanCycles(44);
    checkOutput("lock_after_3_frames", int'(locked8), 1);
    checkOutput("clean_err_count", int'(errCount8), 0);
    cleanCycles(3);
    checkOutput("frame_start_after_data", int'(frameStart8), 1);

    // Dropped set while locked.
    cleanCycle();
    applyStimulus(0, 0, 0, 0);
    checkOutput("drop_set_err_pulse", int'(errPulse8), 1);
    checkOutput("drop_set_code", int'(errCode8), 3);
    checkOutput("drop_set_count", int'(errCount8), 1);
    checkOutput("drop_set_unlock", int'(locked8), 0);
    cleanCycles(40);
    checkOutput("relock", int'(locked8), 1);

    // Extra state strobe at phase 8, then data at phase 5.
    advanceTo(8);
    applyStimulus(0, 0, 1, 0);
    checkOutput("extra_state_code", int'(errCode8), 6);
    checkOutput("extra_state_count", int'(errCount8), 2);
    advanceTo(5);
    applyStimulus(1, 0, 0, 0);
    checkOutput("extra_data_code", int'(errCode8), 2);

    // Collision in TRACK, then collision in HUNT.
    advanceTo(DATA_POS);
    cleanCycle();
    advanceTo(DATA_POS);
    applyStimulus(1, 1, 0, 0);
    checkOutput("track_collision_code", int'(errCode8), 7);
    advanceTo(DATA_POS);
    applyStimulus(1, 1, 0, 0);
    checkOutput("hunt_collision_code", int'(errCode8), 7);
    checkOutput("count8_after_5", int'(errCount8), 5);
    checkOutput("count2_saturated", int'(errCount2), 3);
    cleanCycle();
    checkOutput("no_resync_from_collision", int'(phaseIdx8), 0);

    // Clear coincident with an error: clear first, then count the new error.
    advanceTo(DATA_POS);
    cleanCycle();
    cleanCycle();
    applyStimulus(0, 0, 0, 1);
    checkOutput("clr_with_err_count8", int'(errCount8), 1);
    checkOutput("clr_with_err_count2", int'(errCount2), 1);
    checkOutput("clr_with_err_code", int'(errCode8), 3);

    // Randomized frames with sparse faults and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      logic d, s, t, c;
      d = (genPhase == DATA_POS);
      s = (genPhase == SET_POS);
      t = (genPhase == STATE_POS);
      if ($urandom_range(0, 99) < 2) begin
        case ($urandom_range(0, 2))
          0: d = ~d;
          1: s = ~s;
          default: t = ~t;
        endcase
      end
      c = ($urandom_range(0, 99) < 2);
      applyStimulus(d, s, t, c);
    end

    // Reset mid-frame at phase 5 while locked.
    cleanCycles(50);
    advanceTo(5);
    checkOutput("locked_before_reset", int'(locked8), 1);
    doReset();
    genPhase = 0;

    // Several errors after reset; only the first one is captured.
    advanceTo(DATA_POS);
    cleanCycle();
    advanceTo(SET_POS);
    applyStimulus(0, 0, 0, 0);
    advanceTo(DATA_POS);
    applyStimulus(1, 1, 0, 0);
    checkOutput("last_err_code", int'(errCode8), 7);
    checkOutput("err_count_after_reset", int'(errCount8), 2);
`ifdef PHASE_CHK_FIRST_ERR_EN
    checkOutput("first_err_code_held", int'(firstCode8), 3);
    checkOutput("first_err_phase_held", int'(firstPhase8), 4);
`endif
    cleanCycles(50);
    checkOutput("final_locked", int'(locked8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
